// File: rtl/rns_fwd_conv_if.sv
// Handshake bundle for the binary-to-residue forward converter.
// The slave side is the converter; the master side is whoever supplies operands and takes residues.
interface rns_fwd_conv_if #(
    parameter int N  = 8,
    parameter int XW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  r1;
    logic [N-1:0]  r2;
    logic [N:0]    r3;
    logic [N:0]    r4;
    logic          busy;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, r1, r2, r3, r4, busy
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, r1, r2, r3, r4, busy
    );
endinterface

// File: rtl/rns_fwd_conv.sv
// Sequential binary-to-residue converter for {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}.
// One chunk is folded into every accumulator per cycle, LSB first; results are canonicalised in FIX.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// FOLD  | folding chunk i into acc1/acc3/acc4, K cycles
// FIX   | canonicalise accumulators into r1..r4
// DONE  | residues valid, waiting for out_ready
module rns_fwd_conv #(
    parameter int N  = 8,
    parameter int XW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    rns_fwd_conv_if.slave     bus
);
    localparam int K1 = (XW + N - 1) / N;
    localparam int K4 = (XW + N) / (N + 1);
    localparam int K  = (K1 > K4) ? K1 : K4;
    localparam int CW = $clog2(K) + 1;

    localparam logic [CW-1:0]  C_LAST = CW'(K - 1);
    localparam logic [N+1:0]   C_M3   = {2'b01, {(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  C_ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_FOLD, S_FIX, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [XW-1:0] r_sh1;
    logic [XW-1:0] r_sh4;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_acc1;
    logic [N:0]    r_acc3;
    logic [N:0]    r_acc4;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_r1;
    logic [N-1:0]  r_r2;
    logic [N:0]    r_r3;
    logic [N:0]    r_r4;

    logic          w_last;
    logic [N-1:0]  w_c1;
    logic [N:0]    w_c4;
    logic [N:0]    w_s1;
    logic [N-1:0]  w_acc1_nxt;
    logic [N+1:0]  w_s4;
    logic [N:0]    w_acc4_nxt;
    logic [N+1:0]  w_t3;
    logic [N:0]    w_acc3_nxt;

    assign w_last = (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_nxt = S_FOLD;
            S_FOLD:  if (w_last)        w_state_nxt = S_FIX;
            S_FIX:                      w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_FOLD) || (r_state == S_FIX);
    assign bus.r1        = r_r1;
    assign bus.r2        = r_r2;
    assign bus.r3        = r_r3;
    assign bus.r4        = r_r4;

    // acc3 alternates sign per chunk because 2^N == -1 mod 2^N+1.
    always_comb begin
        w_c1       = r_sh1[N-1:0];
        w_c4       = r_sh4[N:0];
        w_s1       = {1'b0, r_acc1} + {1'b0, w_c1};
        w_acc1_nxt = w_s1[N-1:0] + {{(N-1){1'b0}}, w_s1[N]};
        w_s4       = {1'b0, r_acc4} + {1'b0, w_c4};
        w_acc4_nxt = w_s4[N:0] + {{N{1'b0}}, w_s4[N+1]};
        if (r_cnt[0]) begin
            w_t3 = {1'b0, r_acc3} - {2'b00, w_c1};
            if (w_t3[N+1]) w_t3 = w_t3 + C_M3;
        end else begin
            w_t3 = {1'b0, r_acc3} + {2'b00, w_c1};
            if (w_t3 >= C_M3) w_t3 = w_t3 - C_M3;
        end
        w_acc3_nxt = w_t3[N:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh1  <= '0;
            r_sh4  <= '0;
            r_lo   <= '0;
            r_acc1 <= '0;
            r_acc3 <= '0;
            r_acc4 <= '0;
            r_cnt  <= '0;
            r_r1   <= '0;
            r_r2   <= '0;
            r_r3   <= '0;
            r_r4   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sh1  <= bus.x;
                        r_sh4  <= bus.x;
                        r_lo   <= bus.x[N-1:0];
                        r_acc1 <= '0;
                        r_acc3 <= '0;
                        r_acc4 <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_FOLD: begin
                    r_acc1 <= w_acc1_nxt;
                    r_acc3 <= w_acc3_nxt;
                    r_acc4 <= w_acc4_nxt;
                    r_sh1  <= r_sh1 >> N;
                    r_sh4  <= r_sh4 >> (N + 1);
                    r_cnt  <= r_cnt + C_ONE;
                end
                // The all-ones value is the second encoding of zero for the 2^k-1 channels.
                S_FIX: begin
                    r_r1 <= (r_acc1 == {N{1'b1}})     ? '0 : r_acc1;
                    r_r2 <= r_lo;
                    r_r3 <= r_acc3;
                    r_r4 <= (r_acc4 == {(N+1){1'b1}}) ? '0 : r_acc4;
                end
                default: ;
            endcase
        end
    end
endmodule
